mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all ports.
REQ-002 Parameter: DATA_W, 32, data width of all ports.
REQ-003 Parameter: TIMEOUT, 16, cycles in a busy state without mem_ack before the transaction is aborted.
REQ-004 Parameter: STARVE_LIM, 4, consecutive data grants while if_req is pending before fetch is forced.
REQ-005 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 Port: rst  in  1  reset, asynchronous, active-low.
REQ-007 Port: if_req  in  1  fetch request, held high until if_ack.
REQ-008 Port: if_addr  in  ADDR_W  fetch address, stable while if_req is high.
REQ-009 Port: if_ack  out  1  one-cycle fetch completion pulse.
REQ-010 Port: if_rdata  out  DATA_W  fetch data, valid when if_ack is high.
REQ-011 Port: dm_req, dm_we  in  1 each  data request and write enable, held until dm_ack.
REQ-012 Port: dm_addr, dm_wdata  in  ADDR_W, DATA_W  data address and write data.
REQ-013 Port: dm_ack  out  1  one-cycle data completion pulse.
REQ-014 Port: dm_rdata  out  DATA_W  read data, valid when dm_ack is high.
REQ-015 Port: err  out  1  pulse coincident with if_ack or dm_ack when the transaction timed out.
REQ-016 Port: mem_req, mem_we  out  1 each  registered request and write enable to the single memory port.
REQ-017 Port: mem_addr, mem_wdata  out  ADDR_W, DATA_W  registered address and write data.
REQ-018 Port: mem_ack  in  1  memory completion pulse; mem_rdata  in  DATA_W  read data.
REQ-019 Port: stall_if, stall_mem  out  1 each  pipeline stalls to the hazard unit.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, I_BUSY and D_BUSY.
REQ-021 In IDLE, dm_req SHALL win over if_req unless starve_cnt equals STARVE_LIM and if_req is high, in which case fetch SHALL win.
REQ-022 On a grant, mem_req, mem_we, mem_addr and mem_wdata SHALL be registered from the winner, and the FSM SHALL enter I_BUSY or D_BUSY in the next cycle; for fetch, mem_we SHALL be 0.
REQ-023 In a busy state, mem_ack=1 SHALL produce the owner's ack combinationally in the same cycle, and rdata SHALL pass through mem_rdata.
REQ-024 On that same edge, mem_req SHALL drop and the FSM SHALL return to IDLE, giving a minimum of 2 cycles from request to ack and one idle cycle between grants.
REQ-025 starve_cnt SHALL increment on each data grant made while if_req is high, saturating at STARVE_LIM, and SHALL clear on any fetch grant.
REQ-026 A watchdog SHALL count cycles in a busy state; when it reaches TIMEOUT without mem_ack, the arbiter SHALL pulse the owner's ack together with err, drop mem_req, and return to IDLE.
REQ-027 If the watchdog reaches TIMEOUT in the same cycle that mem_ack is high, the transaction SHALL complete normally with err=0.
REQ-028 The watchdog SHALL clear on every entry to IDLE.
REQ-029 mem_ack received in IDLE SHALL be ignored and SHALL produce no ack.
REQ-030 stall_if SHALL equal if_req & ~if_ack, and stall_mem SHALL equal dm_req & ~dm_ack, both combinationally.
REQ-031 When both requests are absent, the FSM SHALL remain in IDLE with mem_req=0.

Reset
REQ-032 Asserting rst (low) SHALL force IDLE, clear both counters and clear every registered output to 0, independent of clk.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction with no ack issued; after release, a still-pending request SHALL be re-arbitrated from IDLE.

Structure
REQ-034 The state enum, ADDR_W and DATA_W defaults SHALL live in the shared package mips_mem_pkg.
REQ-035 The timeout counter SHALL be the sub-module arb_watchdog, with inputs clk, rst, clr and en and output expired.

Verification
REQ-036 A single fetch with if_addr=0x40 and mem_ack one cycle after mem_req SHALL yield if_ack at cycle 2, mem_addr=0x40, mem_we=0 and err=0.
REQ-037 Simultaneous if_req and dm_req (write, addr 84, wdata 7) SHALL grant data first, with mem_we=1, mem_addr=84 and mem_wdata=7; fetch SHALL be granted after dm_ack.
REQ-038 With if_req held high and dm_req re-asserted after every ack, STARVE_LIM=4 SHALL yield 4 data grants, then 1 fetch grant, and then starve_cnt=0.
REQ-039 A transaction with mem_ack never asserted SHALL yield dm_ack=1 and err=1 exactly TIMEOUT=16 cycles after entering D_BUSY, and the arbiter SHALL return to IDLE.
REQ-040 With rst asserted low during D_BUSY, all outputs SHALL go to 0 immediately and no dm_ack SHALL occur; after release with dm_req still high, a new grant SHALL follow.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and width defaults for the memory arbiter
package mips_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - busy-cycle counter that flags a stuck memory transaction
module arb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Holds at TIMEOUT so expired stays asserted until the owner clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == CW'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto a single memory port with starvation guard and timeout
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int TIMEOUT    = 16,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int SW = $clog2(STARVE_LIM + 1);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] starve_cnt;
    logic          grant_if, grant_dm, done, busy, expired, starve_hit;

    assign busy       = (state_q != IDLE);
    assign starve_hit = if_req && (starve_cnt == SW'(STARVE_LIM));

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!busy),
        .en      (busy),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_req && !starve_hit) begin
                    grant_dm = 1'b1;
                    state_d  = D_BUSY;
                end else if (if_req) begin
                    grant_if = 1'b1;
                    state_d  = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_ack || expired) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A real mem_ack in the expiry cycle wins, so err only marks true aborts
    assign if_ack   = done && (state_q == I_BUSY);
    assign dm_ack   = done && (state_q == D_BUSY);
    assign err      = done && !mem_ack;
    assign if_rdata = mem_rdata;
    assign dm_rdata = mem_rdata;

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_dm) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
        end else if (grant_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
        end else if (done) begin
            mem_req   <= 1'b0;
        end
    end

    // Counts data grants that bypassed a waiting fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_dm && if_req && (starve_cnt != SW'(STARVE_LIM))) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a randomized memory responder
module tb_mem_arbiter;

    localparam int TO = 16;
    localparam int SL = 4;

    logic        clk, rst;
    logic        if_req, if_ack, dm_req, dm_we, dm_ack, err;
    logic        mem_req, mem_we, mem_ack, stall_if, stall_mem;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        mem_auto, rand_lat, man_ack, auto_ack;
    logic [31:0] man_rdata, auto_rdata;
    int          fixed_lat, lat_left;
    logic [31:0] mem_store [256];
    logic [31:0] shadow [256];
    int          checks, failures;

    assign mem_ack   = mem_auto ? auto_ack : man_ack;
    assign mem_rdata = mem_auto ? auto_rdata : man_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .STARVE_LIM(SL)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory device: acks lat_left cycles after first seeing mem_req
    initial begin
        for (int i = 0; i < 256; i++) mem_store[i] = 32'hA500_0000 | (i * 7);
        auto_ack = 1'b0; auto_rdata = '0; lat_left = 1;
        forever begin
            @(posedge clk); #1;
            if (mem_auto && mem_req && !auto_ack) begin
                if (lat_left <= 0) begin
                    auto_ack = 1'b1;
                    if (mem_we) mem_store[mem_addr[7:0]] = mem_wdata;
                    else auto_rdata = mem_store[mem_addr[7:0]];
                end else begin
                    lat_left--;
                end
            end else begin
                auto_ack = 1'b0;
                lat_left = rand_lat ? int'($urandom_range(1, 3)) : fixed_lat;
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_req_we: got %b%b expected 00", mem_req, mem_we); end
        checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin failures++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", mem_addr, mem_wdata); end
        checks++; if (if_ack !== 1'b0 || dm_ack !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_acks: got %b%b%b expected 000", if_ack, dm_ack, err); end
        @(posedge clk); #1; rst = 1'b1; man_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++; if (if_ack !== 1'b0 || dm_ack !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL idle_ack_ignored: got if_ack=%b dm_ack=%b mem_req=%b expected 000", if_ack, dm_ack, mem_req); end
        end
        @(posedge clk); #1; man_ack = 1'b0;
    endtask

    task automatic test_single_fetch();
        int got;
        got = -1;
        mem_auto = 1'b1; rand_lat = 1'b0; fixed_lat = 1;
        @(posedge clk); #1; if_req = 1'b1; if_addr = 32'h40;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (if_ack) begin
                got = c;
                checks++; if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin failures++; $display("FAIL fetch_fields: got addr=%h we=%b expected 40/0", mem_addr, mem_we); end
                checks++; if (err !== 1'b0) begin failures++; $display("FAIL fetch_err: got %b expected 0", err); end
                checks++; if (if_rdata !== shadow[8'h40]) begin failures++; $display("FAIL fetch_rdata: got %h expected %h", if_rdata, shadow[8'h40]); end
                break;
            end
            @(posedge clk); #1;
        end
        checks++; if (got != 2) begin failures++; $display("FAIL fetch_latency: got %0d expected 2", got); end
        @(posedge clk); #1; if_req = 1'b0;
    endtask

    task automatic test_priority();
        int g;
        logic gd, gi, drop_d, drop_i, prev;
        g = 0; gd = 0; gi = 0; prev = 0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h110;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd84; dm_wdata = 32'd7;
        for (int c = 0; c < 30 && !(gd && gi); c++) begin
            @(negedge clk);
            drop_d = 0; drop_i = 0;
            if (mem_req && !prev) begin
                g++;
                if (g == 1) begin
                    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'd84 || mem_wdata !== 32'd7) begin failures++; $display("FAIL prio_first_grant: got we=%b addr=%0d wdata=%0d expected 1/84/7", mem_we, mem_addr, mem_wdata); end
                end else if (g == 2) begin
                    checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h110) begin failures++; $display("FAIL prio_second_grant: got we=%b addr=%h expected 0/110", mem_we, mem_addr); end
                end
            end
            prev = mem_req;
            if (dm_ack) begin gd = 1; drop_d = 1; shadow[84] = 32'd7; end
            if (if_ack) begin
                gi = 1; drop_i = 1;
                checks++; if (!gd) begin failures++; $display("FAIL prio_order: got fetch ack before data ack expected data first"); end
                checks++; if (if_rdata !== shadow[8'h10]) begin failures++; $display("FAIL prio_fetch_rdata: got %h expected %h", if_rdata, shadow[8'h10]); end
            end
            @(posedge clk); #1;
            if (drop_d) dm_req = 1'b0;
            if (drop_i) if_req = 1'b0;
        end
        checks++; if (!(gd && gi)) begin failures++; $display("FAIL prio_timeout: got dm=%b if=%b expected both acked", gd, gi); end
    endtask

    task automatic test_starve();
        int  k, sm;
        logic exp_i;
        k = 0; sm = 0;
        rand_lat = 1'b1;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h104;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h208;
        for (int c = 0; c < 300 && k < 10; c++) begin
            @(negedge clk);
            if (if_ack || dm_ack) begin
                exp_i = (sm == SL);
                checks++; if (if_ack !== exp_i || dm_ack !== !exp_i) begin failures++; $display("FAIL starve_order: txn %0d got if_ack=%b dm_ack=%b expected if_ack=%b", k, if_ack, dm_ack, exp_i); end
                checks++;
                if (exp_i && if_rdata !== shadow[8'h04]) begin failures++; $display("FAIL starve_if_rdata: got %h expected %h", if_rdata, shadow[8'h04]); end
                else if (!exp_i && dm_rdata !== shadow[8'h08]) begin failures++; $display("FAIL starve_dm_rdata: got %h expected %h", dm_rdata, shadow[8'h08]); end
                sm = exp_i ? 0 : ((sm < SL) ? sm + 1 : sm);
                k++;
            end
            @(posedge clk); #1;
        end
        checks++; if (k != 10) begin failures++; $display("FAIL starve_count: got %0d acks expected 10", k); end
        if_req = 1'b0; dm_req = 1'b0;
    endtask

    task automatic test_timeout(input logic race);
        int   got;
        logic entered, e;
        got = -1; entered = 0; e = 1'bx;
        mem_auto = 1'b0; man_ack = 1'b0; man_rdata = 32'h0DEA_0016;
        @(posedge clk); #1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h30;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (mem_req) begin entered = 1; break; end
            @(posedge clk); #1;
        end
        checks++; if (!entered) begin failures++; $display("FAIL to_grant: got no mem_req expected grant"); end
        for (int n = 1; n <= TO + 8; n++) begin
            @(posedge clk); #1; man_ack = race && (n == TO);
            @(negedge clk);
            if (dm_ack) begin got = n; e = err; break; end
        end
        checks++; if (got != TO) begin failures++; $display("FAIL to_cycle race=%b: got %0d expected %0d", race, got, TO); end
        checks++; if (e !== !race) begin failures++; $display("FAIL to_err race=%b: got %b expected %b", race, e, !race); end
        @(posedge clk); #1; man_ack = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL to_release race=%b: got mem_req=%b expected 0", race, mem_req); end
    endtask

    task automatic test_reset_mid();
        logic entered, regrant;
        entered = 0; regrant = 0;
        mem_auto = 1'b0; man_ack = 1'b0;
        @(posedge clk); #1; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h55; dm_wdata = 32'h99;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (mem_req) begin entered = 1; break; end
            @(posedge clk); #1;
        end
        checks++; if (!entered) begin failures++; $display("FAIL rm_grant: got no mem_req expected grant"); end
        #2; rst = 1'b0; man_ack = 1'b1; #1;
        checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin failures++; $display("FAIL rm_async_clear: got req=%b we=%b addr=%h wdata=%h expected all 0", mem_req, mem_we, mem_addr, mem_wdata); end
        checks++; if (dm_ack !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rm_no_ack: got dm_ack=%b err=%b expected 00", dm_ack, err); end
        repeat (3) begin
            @(negedge clk);
            checks++; if (dm_ack !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL rm_held: got dm_ack=%b mem_req=%b expected 00", dm_ack, mem_req); end
        end
        @(posedge clk); #1; rst = 1'b1; man_ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (mem_req) begin regrant = 1; break; end
            @(posedge clk); #1;
        end
        checks++; if (!regrant || mem_addr !== 32'h55 || mem_we !== 1'b1 || mem_wdata !== 32'h99) begin failures++; $display("FAIL rm_regrant: got grant=%b addr=%h we=%b wdata=%h expected 1/55/1/99", regrant, mem_addr, mem_we, mem_wdata); end
        @(posedge clk); #1; man_ack = 1'b1;
        @(negedge clk);
        checks++; if (dm_ack !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL rm_complete: got dm_ack=%b err=%b expected 10", dm_ack, err); end
        @(posedge clk); #1; man_ack = 1'b0; dm_req = 1'b0;
    endtask

    task automatic test_random();
        logic di, dd, prev_mreq, prev_if, prev_dm, owner_d;
        int   sm;
        di = 0; dd = 0; prev_mreq = 0; prev_if = 0; prev_dm = 0; owner_d = 0; sm = 0;
        mem_auto = 1'b1; rand_lat = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (di) begin if_req = 1'b0; di = 0; end
            else if (!if_req && c < 340 && $urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = $urandom; end
            if (dd) begin dm_req = 1'b0; dd = 0; end
            else if (!dm_req && c < 340 && $urandom_range(0, 2) == 0) begin
                dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom; dm_wdata = $urandom;
            end
            @(negedge clk);
            checks++; if (stall_if !== (if_req & ~if_ack) || stall_mem !== (dm_req & ~dm_ack)) begin failures++; $display("FAIL rnd_stall: got %b%b expected %b%b", stall_if, stall_mem, if_req & ~if_ack, dm_req & ~dm_ack); end
            if (mem_req && !prev_mreq) begin
                checks++;
                if (!prev_if && !prev_dm) begin
                    failures++; $display("FAIL rnd_spurious_grant: got mem_req=1 expected 0");
                end else begin
                    owner_d = prev_dm && !(sm == SL && prev_if);
                    if (owner_d) begin
                        if (mem_addr !== dm_addr || mem_we !== dm_we || mem_wdata !== dm_wdata) begin failures++; $display("FAIL rnd_dm_grant: got addr=%h we=%b wdata=%h expected %h/%b/%h", mem_addr, mem_we, mem_wdata, dm_addr, dm_we, dm_wdata); end
                        if (prev_if && sm < SL) sm++;
                    end else begin
                        if (mem_addr !== if_addr || mem_we !== 1'b0) begin failures++; $display("FAIL rnd_if_grant: got addr=%h we=%b expected %h/0", mem_addr, mem_we, if_addr); end
                        sm = 0;
                    end
                end
            end
            if (dm_ack) begin
                dd = 1;
                checks++; if (!owner_d || err !== 1'b0) begin failures++; $display("FAIL rnd_dm_ack: got owner_d=%b err=%b expected 1/0", owner_d, err); end
                if (dm_we) shadow[dm_addr[7:0]] = dm_wdata;
                else begin
                    checks++; if (dm_rdata !== shadow[dm_addr[7:0]]) begin failures++; $display("FAIL rnd_dm_rdata: got %h expected %h", dm_rdata, shadow[dm_addr[7:0]]); end
                end
            end
            if (if_ack) begin
                di = 1;
                checks++; if (owner_d || err !== 1'b0) begin failures++; $display("FAIL rnd_if_ack: got owner_d=%b err=%b expected 0/0", owner_d, err); end
                checks++; if (if_rdata !== shadow[if_addr[7:0]]) begin failures++; $display("FAIL rnd_if_rdata: got %h expected %h", if_rdata, shadow[if_addr[7:0]]); end
            end
            prev_mreq = mem_req; prev_if = if_req; prev_dm = dm_req;
        end
        checks++; if (if_req || dm_req) begin failures++; $display("FAIL rnd_drain: got if_req=%b dm_req=%b expected 00", if_req, dm_req); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        man_ack = 1'b0; man_rdata = '0; mem_auto = 1'b0; rand_lat = 1'b0; fixed_lat = 1;
        for (int i = 0; i < 256; i++) shadow[i] = 32'hA500_0000 | (i * 7);
        test_reset();
        test_single_fetch();
        test_priority();
        test_starve();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
